// File: rtl/alu_serial_seq.sv
// alu_serial_seq
// ----------------------------------------------------------------------------
// Bit-serial ALU sequencer. It accepts an operand pair and a 4-bit control word
// {A_invert, B_invert, op[1:0]}, then computes one result bit per clock, LSB
// first, on a 1-bit datapath with a registered carry. It uses the same control
// encoding and flag semantics as the ripple ALU:
//   op 0 = AND, 1 = OR, 2 = ADD, 3 = SLT (sign of A-B, no overflow correction).
// Sequence: IDLE -> RUN (WIDTH cycles) -> FIN (1 cycle, valid_o) -> IDLE.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous, active-low reset
//   start_i     request, sampled only in IDLE
//   src1_i      operand A, captured when start is accepted
//   src2_i      operand B, captured when start is accepted
//   ctrl_i      {A_invert, B_invert, op[1:0]}, captured when start is accepted
//   busy_o      high in RUN and FIN
//   valid_o     one-cycle pulse in FIN; result and flags are valid
//   result_o    packed result, held between operations
//   zero_o      result_o == 0
//   cout_o      carry out of the MSB (ADD/SUB only)
//   overflow_o  signed overflow (ADD/SUB only)
// ----------------------------------------------------------------------------
module alu_serial_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    // Only WIDTH-1 bits are stored: the final bit goes straight from the
    // datapath into result_o on the last RUN cycle.
    logic [WIDTH-2:0] shreg;

    logic             bit_a;
    logic             bit_b;
    logic             sum;
    logic             carry_nx;
    logic             rbit;
    logic             last;
    logic [WIDTH-1:0] shift_nx;
    logic [WIDTH-1:0] res_fin;
    logic             ovf_bit;

    // ------------------------------------------------------------------
    // 1-bit datapath
    // ------------------------------------------------------------------
    always_comb begin
        bit_a    = opa[cnt] ^ ctrl[3];
        bit_b    = opb[cnt] ^ ctrl[2];
        sum      = bit_a ^ bit_b ^ carry;
        carry_nx = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
        ovf_bit  = (bit_a & bit_b & ~sum) | (~bit_a & ~bit_b & sum);
        last     = (cnt == CNT_W'(WIDTH - 1));

        case (ctrl[1:0])
            2'd0:    rbit = bit_a & bit_b;
            2'd1:    rbit = bit_a | bit_b;
            2'd2:    rbit = sum;
            default: rbit = 1'b0;
        endcase

        shift_nx = {rbit, shreg};

        // SLT reports only the MSB sum bit, placed in bit 0.
        if (ctrl[1:0] == 2'd3) begin
            res_fin = WIDTH'(sum);
        end else begin
            res_fin = shift_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy_o   = 1'b0;
        valid_o  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                busy_o   = 1'b1;
                valid_o  = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture, serial state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            opa        <= '0;
            opb        <= '0;
            ctrl       <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            shreg      <= '0;
            result_o   <= '0;
            zero_o     <= 1'b1;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        opa   <= src1_i;
                        opb   <= src2_i;
                        ctrl  <= ctrl_i;
                        cnt   <= '0;
                        carry <= ctrl_i[2];
                    end
                end
                RUN: begin
                    carry <= carry_nx;
                    shreg <= shift_nx[WIDTH-1:1];
                    if (last) begin
                        // Outputs are loaded on the edge into FIN so they are
                        // stable for the whole valid_o cycle and held after.
                        result_o   <= res_fin;
                        zero_o     <= (res_fin == '0);
                        cout_o     <= (ctrl[1:0] == 2'd2) ? carry_nx : 1'b0;
                        overflow_o <= (ctrl[1:0] == 2'd2) ? ovf_bit : 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [3:0]   ctrl = '0;
    logic         busy, valid, zero, cout, ovf;
    logic [W-1:0] result;

    int total  = 0;
    int passed = 0;

    alu_serial_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .src1_i     (src1),
        .src2_i     (src2),
        .ctrl_i     (ctrl),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result),
        .zero_o     (zero),
        .cout_o     (cout),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         co;
        logic         ov;
    } res_t;

    typedef struct {
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [3:0]   c;
        logic [W-1:0] r;
        logic         z;
        logic         co;
        logic         ov;
    } vec_t;

    // Reference: whole-word arithmetic on the inverted operands.
    function automatic res_t model(input logic [W-1:0] s1, input logic [W-1:0] s2,
                                   input logic [3:0] c);
        res_t         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   s;
        a = c[3] ? ~s1 : s1;
        b = c[2] ? ~s2 : s2;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c[2]};
        m.co = 1'b0;
        m.ov = 1'b0;
        case (c[1:0])
            2'd0: m.r = a & b;
            2'd1: m.r = a | b;
            2'd2: begin
                m.r  = s[W-1:0];
                m.co = s[W];
                m.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            default: m.r = {{(W-1){1'b0}}, s[W-1]};
        endcase
        m.z = (m.r == '0);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Issue one operation; optionally pulse start again at RUN cycle inject_at.
    // lat counts cycles from the cycle start was presented to the valid cycle.
    task automatic do_op(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [3:0] c,
                         input int inject_at, output res_t got, output int lat);
        @(negedge clk);
        src1 = s1; src2 = s2; ctrl = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
        lat = 1;
        while (!valid && lat < 200) begin
            start = (lat == inject_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        got.r = result; got.z = zero; got.co = cout; got.ov = ovf;
    endtask

    task automatic run_check(input string nm, input logic [W-1:0] s1, input logic [W-1:0] s2,
                             input logic [3:0] c, input res_t exp, input int inject_at);
        res_t got;
        int   lat;
        do_op(s1, s2, c, inject_at, got, lat);
        chk({nm, " latency"}, W'(lat), W'(W + 1));
        chk({nm, " result"}, got.r, exp.r);
        chk({nm, " zero"}, W'(got.z), W'(exp.z));
        chk({nm, " cout"}, W'(got.co), W'(exp.co));
        chk({nm, " ovf"}, W'(got.ov), W'(exp.ov));
        @(negedge clk);
        chk({nm, " valid pulse"}, W'(valid), 0);
        chk({nm, " hold"}, result, exp.r);
        @(negedge clk);
        chk({nm, " idle after"}, W'(busy), 0);
    endtask

    vec_t vecs[11];

    initial begin
        res_t e;
        int   vcount;
        int   t;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'h00000005, 32'h00000007, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, 32'h00000000, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h12340000, 32'h00005678, 4'b0001, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{32'h00000007, 32'h00000005, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h00000001, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h00000003, 32'h00000004, 4'b0010, 32'h00000007, 1'b0, 1'b0, 1'b0};

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        chk("idle result", result, 0);
        chk("idle zero", W'(zero), 1);
        chk("idle busy", W'(busy), 0);
        chk("idle no valid", W'(vcount), 0);

        // Directed vectors
        foreach (vecs[i]) begin
            e.r = vecs[i].r; e.z = vecs[i].z; e.co = vecs[i].co; e.ov = vecs[i].ov;
            run_check($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].c, e, 0);
        end

        // Start pulsed mid-operation is ignored
        e = model(32'h11111111, 32'h22222222, 4'b0010);
        run_check("ignored start", 32'h11111111, 32'h22222222, 4'b0010, e, 10);

        // Back-to-back with start held high
        @(negedge clk);
        src1 = 32'h0000FFFF; src2 = 32'h00000001; ctrl = 4'b0010; start = 1'b1;
        @(negedge clk);
        t = 1;
        while (!valid && t < 200) begin @(negedge clk); t++; end
        chk("b2b first latency", W'(t), W'(W + 1));
        chk("b2b first result", result, 32'h00010000);
        src1 = 32'hAAAA5555; src2 = 32'h0F0F0F0F; ctrl = 4'b0001;
        @(negedge clk);
        t = 1;
        while (!valid && t < 200) begin @(negedge clk); t++; end
        start = 1'b0;
        chk("b2b spacing", W'(t), W'(W + 2));
        chk("b2b second result", result, 32'hAFAF5F5F);
        repeat (2) @(negedge clk);
        chk("b2b idle", W'(busy), 0);

        // Reset mid-RUN
        @(negedge clk);
        src1 = 32'hDEADBEEF; src2 = 32'h01234567; ctrl = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", W'(busy), 0);
        chk("rst valid", W'(valid), 0);
        chk("rst result", result, 0);
        chk("rst zero", W'(zero), 1);
        chk("rst cout", W'(cout), 0);
        chk("rst ovf", W'(ovf), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid || busy) vcount++;
        end
        chk("rst discards op", W'(vcount), 0);
        e = model(32'd3, 32'd4, 4'b0010);
        run_check("post-rst add", 32'd3, 32'd4, 4'b0010, e, 0);

        // Randomized against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [3:0]   c;
            a = $urandom;
            b = $urandom;
            c = 4'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h7FFFFFFF;
                1: b = a;
                2: a = 32'h80000000;
                default: ;
            endcase
            e = model(a, b, c);
            run_check($sformatf("rand%0d c=%b", n, c), a, b, c, e, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
